// File: rtl/keypad_calculator_if.sv
// Key input and display output bundle of the keypad calculator.
// The keypad side drives tipo/number; the calculator drives the display fields.
interface keypad_calculator_if;
  logic        tipo;
  logic [3:0]  number;
  logic [15:0] result;
  logic        ovf;
  logic        sign;

  modport master (output tipo, number, input result, ovf, sign);
  modport slave  (input tipo, number, output result, ovf, sign);
endinterface

// File: rtl/keypad_calculator.sv
// Keypad calculator: key-event decoder FSM, two-operand store and a 16-bit display ALU.
// Each key press is acted on at the same rising edge it is first seen.
module keypad_calculator #(
  parameter int MAX_DIGITS = 4
) (
  input logic                 clk,
  input logic                 reset,
  keypad_calculator_if.slave  kp
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
  localparam logic [4:0]    IDLE_CODE = {1'b0, 4'hF};

  typedef enum logic [1:0] {OP1, OP2, RES} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;
  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_ADD, K_SUB, K_MUL, K_EQ, K_CLR} key_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [4:0]  prev_q;
  logic [15:0] reg1_q, reg1_d, reg2_q, reg2_d;
  logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [15:0] res_q, res_d;
  logic        res_sign_q, res_sign_d, res_ovf_q, res_ovf_d;

  key_t        key;
  logic [15:0] digit;
  logic [26:0] alu_mag;
  logic        alu_sign;
  op_t         key_op;

  assign digit = {12'd0, kp.number};

  // Key decode; X/Z or invalid codes fall to the default arm and are ignored.
  always_comb begin
    key = K_NONE;
    if (kp.tipo == 1'b0) begin
      case (kp.number)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
        4'd5, 4'd6, 4'd7, 4'd8, 4'd9: key = K_DIGIT;
        default:                      key = K_NONE;
      endcase
    end else if (kp.tipo == 1'b1) begin
      case (kp.number)
        4'hA:    key = K_ADD;
        4'hB:    key = K_SUB;
        4'hD:    key = K_MUL;
        4'hC:    key = K_EQ;
        4'hF:    key = K_CLR;
        default: key = K_NONE;
      endcase
    end
    if ({kp.tipo, kp.number} == prev_q) key = K_NONE;
  end

  always_comb begin
    case (key)
      K_SUB:   key_op = OP_SUB;
      K_MUL:   key_op = OP_MUL;
      default: key_op = OP_ADD;
    endcase
  end

  // ALU works at 27 bits so that 9999*9999 is exact before truncation.
  always_comb begin
    alu_sign = 1'b0;
    case (op_q)
      OP_SUB: begin
        if (reg2_q > reg1_q) begin
          alu_mag  = 27'(reg2_q - reg1_q);
          alu_sign = 1'b1;
        end else begin
          alu_mag  = 27'(reg1_q - reg2_q);
        end
      end
      OP_MUL:  alu_mag = 27'(reg1_q) * 27'(reg2_q);
      default: alu_mag = 27'(reg1_q) + 27'(reg2_q);
    endcase
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    reg1_d     = reg1_q;
    reg2_d     = reg2_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    res_d      = res_q;
    res_sign_d = res_sign_q;
    res_ovf_d  = res_ovf_q;

    if (key == K_CLR) begin
      state_d    = OP1;
      op_d       = OP_ADD;
      reg1_d     = '0;
      reg2_d     = '0;
      cnt1_d     = '0;
      cnt2_d     = '0;
      res_d      = '0;
      res_sign_d = 1'b0;
      res_ovf_d  = 1'b0;
    end else begin
      case (state_q)
        OP1: begin
          if (key == K_DIGIT && cnt1_q < MAX_CNT) begin
            reg1_d = 16'(reg1_q * 16'd10) + digit;
            cnt1_d = cnt1_q + 1'b1;
          end else if (key == K_ADD || key == K_SUB || key == K_MUL) begin
            op_d    = key_op;
            reg2_d  = '0;
            cnt2_d  = '0;
            state_d = OP2;
          end
        end
        OP2: begin
          if (key == K_DIGIT && cnt2_q < MAX_CNT) begin
            reg2_d = 16'(reg2_q * 16'd10) + digit;
            cnt2_d = cnt2_q + 1'b1;
          end else if (key == K_ADD || key == K_SUB || key == K_MUL) begin
            op_d = key_op;
          end else if (key == K_EQ) begin
            res_d      = alu_mag[15:0];
            res_sign_d = alu_sign && (alu_mag != '0);
            res_ovf_d  = alu_mag > 27'd9999;
            state_d    = RES;
          end
        end
        RES: begin
          if (key == K_DIGIT) begin
            reg1_d     = digit;
            cnt1_d     = CW'(1);
            reg2_d     = '0;
            cnt2_d     = '0;
            res_d      = '0;
            res_sign_d = 1'b0;
            res_ovf_d  = 1'b0;
            state_d    = OP1;
          end else if ((key == K_ADD || key == K_SUB || key == K_MUL) &&
                       !res_sign_q && !res_ovf_q) begin
            // A chained result is never extended with more digits.
            reg1_d  = res_q;
            cnt1_d  = MAX_CNT;
            op_d    = key_op;
            reg2_d  = '0;
            cnt2_d  = '0;
            state_d = OP2;
          end
        end
        default: state_d = OP1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= OP1;
      op_q       <= OP_ADD;
      prev_q     <= IDLE_CODE;
      reg1_q     <= '0;
      reg2_q     <= '0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      res_q      <= '0;
      res_sign_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      prev_q     <= {kp.tipo, kp.number};
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      res_q      <= res_d;
      res_sign_q <= res_sign_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  always_comb begin
    kp.result = '0;
    kp.sign   = 1'b0;
    kp.ovf    = 1'b0;
    case (state_q)
      OP1: kp.result = reg1_q;
      OP2: kp.result = reg2_q;
      RES: begin
        kp.result = res_q;
        kp.sign   = res_sign_q;
        kp.ovf    = res_ovf_q;
      end
      default: kp.result = '0;
    endcase
  end

endmodule

// File: tb/tb_keypad_calculator.sv
// Directed bench for keypad_calculator: operand entry, the three operations,
// clear, chaining from a result, digit limit and asynchronous reset.
module tb_keypad_calculator;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  keypad_calculator_if kp ();

  keypad_calculator #(.MAX_DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] r, input logic s, input logic o);
    checks++;
    assert (kp.result === r && kp.sign === s && kp.ovf === o)
    else begin
      errors++;
      $error("FAIL %s: got result=%0d sign=%b ovf=%b, want result=%0d sign=%b ovf=%b",
             tag, kp.result, kp.sign, kp.ovf, r, s, o);
    end
  endtask

  // Present a code for one clock; sampled #1 after the edge.
  task automatic press(input logic t, input logic [3:0] n);
    @(negedge clk);
    kp.tipo   = t;
    kp.number = n;
    @(posedge clk);
    #1;
  endtask

  // A key followed by an idle cycle, so the same key can be repeated.
  task automatic key(input logic t, input logic [3:0] n);
    press(t, n);
    press(1'b0, 4'hF);
  endtask

  initial begin
    reset     = 1'b0;
    kp.tipo   = 1'b0;
    kp.number = 4'hF;
    #3;
    check("reset_state", 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    press(1'b0, 4'hF);
    press(1'b0, 4'hF);
    check("idle_hold", 16'd0, 1'b0, 1'b0);

    // A held key counts once.
    press(1'b0, 4'd5);
    press(1'b0, 4'd5);
    press(1'b0, 4'd5);
    check("held_key_once", 16'd5, 1'b0, 1'b0);
    key(1'b1, 4'hF);
    check("clear_after_hold", 16'd0, 1'b0, 1'b0);

    // 12 - 78 with an invalid code between 7 and 8.
    press(1'b0, 4'd1);
    press(1'b0, 4'd2);
    check("entry_12", 16'd12, 1'b0, 1'b0);
    press(1'b1, 4'hB);
    check("op2_starts_zero", 16'd0, 1'b0, 1'b0);
    press(1'b0, 4'd7);
    press(1'b0, 4'hE);
    press(1'b0, 4'd8);
    check("entry_78_invalid_skip", 16'd78, 1'b0, 1'b0);
    press(1'b1, 4'hC);
    check("sub_negative", 16'd66, 1'b1, 1'b0);

    // Clear from RES, equals ignored in OP1, then a digit.
    press(1'b1, 4'hF);
    check("clear_from_res", 16'd0, 1'b0, 1'b0);
    press(1'b1, 4'hC);
    check("equals_in_op1", 16'd0, 1'b0, 1'b0);
    press(1'b0, 4'd8);
    check("digit_after_clear", 16'd8, 1'b0, 1'b0);

    // 9999 + 9999 overflows the display range.
    key(1'b1, 4'hF);
    for (int i = 0; i < 4; i++) key(1'b0, 4'd9);
    check("entry_9999", 16'd9999, 1'b0, 1'b0);
    key(1'b1, 4'hA);
    for (int i = 0; i < 4; i++) key(1'b0, 4'd9);
    key(1'b1, 4'hC);
    check("add_overflow", 16'd19998, 1'b0, 1'b1);

    // Fifth digit is dropped; digit from RES starts a new operand.
    key(1'b0, 4'd1);
    key(1'b0, 4'd2);
    key(1'b0, 4'd3);
    key(1'b0, 4'd4);
    key(1'b0, 4'd5);
    check("digit_limit", 16'd1234, 1'b0, 1'b0);

    // 5 - 5 gives an unsigned zero.
    key(1'b1, 4'hF);
    key(1'b0, 4'd5);
    key(1'b1, 4'hB);
    key(1'b0, 4'd5);
    key(1'b1, 4'hC);
    check("sub_zero", 16'd0, 1'b0, 1'b0);

    // 9999 * 9999 = 99980001; display shows the low 16 bits.
    key(1'b1, 4'hF);
    for (int i = 0; i < 4; i++) key(1'b0, 4'd9);
    key(1'b1, 4'hD);
    for (int i = 0; i < 4; i++) key(1'b0, 4'd9);
    key(1'b1, 4'hC);
    check("mul_overflow", 16'd37601, 1'b0, 1'b1);
    key(1'b1, 4'hA);
    check("no_chain_on_ovf", 16'd37601, 1'b0, 1'b1);

    // 25 * 4 = 100, then chained + 5 = 105.
    key(1'b0, 4'd2);
    key(1'b0, 4'd5);
    key(1'b1, 4'hD);
    key(1'b0, 4'd4);
    key(1'b1, 4'hC);
    check("mul_25x4", 16'd100, 1'b0, 1'b0);
    key(1'b1, 4'hA);
    check("chain_to_op2", 16'd0, 1'b0, 1'b0);
    key(1'b0, 4'd5);
    key(1'b1, 4'hC);
    check("chain_add", 16'd105, 1'b0, 1'b0);

    // Reset in the middle of operand 2 acts without a clock edge.
    key(1'b1, 4'hF);
    key(1'b0, 4'd3);
    key(1'b1, 4'hA);
    key(1'b0, 4'd4);
    check("before_async_reset", 16'd4, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    key(1'b0, 4'd6);
    check("after_reset_digit", 16'd6, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
